// File: rtl/addsub_pkg.sv
// Shared encodings for the add/sub arbiter: FSM states and opcode values.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/Add_Sub_Nbit.sv
// N-bit signed adder/subtractor with an exact (N+1)-bit result.
// k=0 gives A+B, k=1 gives A-B; purely combinational.
module Add_Sub_Nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         k,
  output logic [N:0]   S
);

  logic [N:0] a_ext;
  logic [N:0] b_ext;

  // Sign-extend by one bit so the sum or difference can never overflow.
  assign a_ext = {A[N-1], A};
  assign b_ext = {B[N-1], B} ^ {(N+1){k}};
  assign S     = a_ext + b_ext + {{N{1'b0}}, k};

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one Add_Sub_Nbit among NREQ requesters.
// Operands are held for a multicycle window, then the result is returned on a valid/ready channel.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*N-1:0]       req_a,
  input  logic [NREQ*N-1:0]       req_b,
  input  logic [NREQ-1:0]         req_sub,
  output logic [NREQ-1:0]         req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [N:0]              resp_data,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  // The adder settles for LAT full cycles after the operand registers load,
  // so the capture edge is LAT+1 edges after acceptance.
  localparam logic [3:0] CNT_LOAD = 4'(LAT);

  state_e         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [3:0]     cnt_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           sub_q;
  logic [IDW-1:0] id_q;
  logic           resp_valid_q;
  logic [N:0]     resp_data_q;
  logic [IDW-1:0] resp_id_q;
  logic           busy_q;

  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic           sel_sub;
  logic [IDW-1:0] sel_id;
  logic [IDW-1:0] rr_ptr_d;
  logic [N:0]     sum;

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [IDW-1:0]  ptr);
    logic [NREQ-1:0] g;
    logic            found;
    int              idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && v[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Grant is forced low while reset is asserted so it clears with the registers.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == ST_IDLE) begin
      req_ready = rr_pick(req_valid, rr_ptr_q);
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = OP_ADD;
    sel_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_a   = req_a[i*N +: N];
        sel_b   = req_b[i*N +: N];
        sel_sub = req_sub[i] ? OP_SUB : OP_ADD;
        sel_id  = IDW'(i);
      end
    end
    rr_ptr_d = (sel_id == IDW'(NREQ - 1)) ? '0 : sel_id + 1'b1;
  end

  Add_Sub_Nbit #(.N(N)) u_addsub (
    .A (a_q),
    .B (b_q),
    .k (sub_q),
    .S (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= OP_ADD;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_ready) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            sub_q    <= sel_sub;
            id_q     <= sel_id;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= CNT_LOAD;
            busy_q   <= 1'b1;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            resp_data_q  <= sum;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter (N=8, NREQ=4, LAT=2): cycle model plus directed literal checks.
`timescale 1ns/1ps
module tb_addsub_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic [NREQ-1:0]   req_sub = '0;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [N:0]        resp_data;
  logic [1:0]        resp_id;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  addsub_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [NREQ-1:0] m_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return NREQ'(1) << ((ptr + k) % NREQ);
    end
    return '0;
  endfunction

  function automatic int m_idx(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic logic [N:0] m_calc(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = s ? sa - sb : sa + sb;
    return r[N:0];
  endfunction

  bit              m_work, m_hold;
  int              m_wait, m_ptr;
  logic [N:0]      m_data, m_pend_data;
  logic [1:0]      m_id, m_pend_id;
  logic [NREQ-1:0] m_grant;

  always_comb begin
    m_grant = '0;
    if (!m_work && !m_hold) m_grant = m_pick(req_valid, m_ptr);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_work <= 1'b0; m_hold <= 1'b0; m_wait <= 0; m_ptr <= 0;
      m_data <= '0; m_id <= '0; m_pend_data <= '0; m_pend_id <= '0;
    end else if (m_hold) begin
      if (resp_ready) m_hold <= 1'b0;
    end else if (m_work) begin
      if (m_wait == 1) begin
        m_work <= 1'b0; m_hold <= 1'b1; m_data <= m_pend_data; m_id <= m_pend_id;
      end else begin
        m_wait <= m_wait - 1;
      end
    end else if (m_grant != '0) begin
      m_pend_data <= m_calc(req_a[m_idx(m_grant)*N +: N], req_b[m_idx(m_grant)*N +: N],
                            req_sub[m_idx(m_grant)]);
      m_pend_id   <= 2'(m_idx(m_grant));
      m_ptr       <= (m_idx(m_grant) + 1) % NREQ;
      m_work      <= 1'b1;
      m_wait      <= LAT + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(m_grant));
      chk("busy", 32'(busy), 32'(m_work || m_hold));
      chk("resp_valid", 32'(resp_valid), 32'(m_hold));
      chk("resp_data", 32'(resp_data), 32'(m_data));
      chk("resp_id", 32'(resp_id), 32'(m_id));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       output logic [NREQ-1:0] g, output logic [N:0] d, output logic [1:0] rid,
                       output int lat);
    int k;
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_sub[id]      = s;
    req_valid        = NREQ'(1) << id;
    #1;
    k = 0;
    while (!req_ready[id] && k < 30) begin
      @(posedge clk); #1; k++;
    end
    chk("grant_in_time", 32'(k < 30), 32'd1);
    g = req_ready;
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0;
    while (!resp_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    d   = resp_data;
    rid = resp_id;
    $display("[TB] op req=%0d a=%0d b=%0d sub=%0d -> data=0x%0h id=%0d lat=%0d",
             id, $signed(a), $signed(b), s, d, rid, lat);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || resp_valid) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("idle_in_time", 32'(k < 50), 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [NREQ-1:0] g;
  logic [N:0]      d, held_d;
  logic [1:0]      rid, held_id;
  int              lat;

  initial begin : main
    int exp_order[5];
    logic [N:0] exp_sum[NREQ];
    int ngrant, nresp, cyc, acc, maxw, pend_g;
    int waits[NREQ];
    int grants[NREQ];

    // reset state, with requests already pending
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // single add, then signed subtraction and add with cancellation
    do_op(0, 8'd100, 8'd50, 1'b0, g, d, rid, lat);
    chk("t1_grant", 32'(g), 32'b0001);
    chk("t1_latency", 32'(lat), 32'(LAT + 1));
    chk("t1_data", 32'(d), 32'd150);
    chk("t1_id", 32'(rid), 32'd0);
    do_op(2, 8'h9C, 8'd100, 1'b1, g, d, rid, lat);
    chk("t2_sub_data", 32'(d), 32'h138);
    chk("t2_sub_id", 32'(rid), 32'd2);
    do_op(2, 8'h9C, 8'd100, 1'b0, g, d, rid, lat);
    chk("t2_add_data", 32'(d), 32'd0);
    wait_idle();

    // round-robin from a fresh reset with all requesters asserting
    rst_n = 1'b0; #2; rst_n = 1'b1;
    exp_order = '{0, 1, 2, 3, 0};
    exp_sum   = '{9'd6, 9'd21, 9'd52, 9'd55};
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 8'(i * 20 + 5);
      req_b[i*N +: N] = 8'(i * 3 + 1);
      req_sub[i]      = i[0];
    end
    req_valid = 4'hF;
    ngrant = 0; nresp = 0; cyc = 0;
    #1;
    while (ngrant < 5 && cyc < 100) begin
      if (resp_valid) begin
        chk("rr_resp_id", 32'(resp_id), 32'(exp_order[nresp]));
        chk("rr_resp_data", 32'(resp_data), 32'(exp_sum[resp_id]));
        $display("[TB] rr resp id=%0d data=%0d", resp_id, resp_data);
        nresp++;
      end
      if (req_ready != '0) begin
        chk("rr_grant", 32'(req_ready), 32'(NREQ'(1) << exp_order[ngrant]));
        ngrant++;
      end
      if (ngrant < 5) begin
        @(posedge clk); #1; cyc++;
      end
    end
    chk("rr_all_grants", 32'(ngrant), 32'd5);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // back-pressure: result must hold and no grant may issue
    resp_ready = 1'b0;
    req_a[1*N +: N] = 8'd7; req_b[1*N +: N] = 8'd9; req_sub[1] = 1'b1;
    req_valid = 4'b0010;
    #1;
    cyc = 0;
    while (!req_ready[1] && cyc < 30) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    req_valid = 4'b0001;
    cyc = 0;
    while (!resp_valid && cyc < 30) begin @(posedge clk); #1; cyc++; end
    held_d = resp_data; held_id = resp_id;
    chk("bp_data", 32'(held_d), 32'h1FE);
    chk("bp_id", 32'(held_id), 32'd1);
    $display("[TB] bp resp id=%0d data=0x%0h held", held_id, held_d);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_data", 32'(resp_data), 32'h1FE);
      chk("bp_hold_id", 32'(resp_id), 32'd1);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_hs_no_grant", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_valid_drop", 32'(resp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    cyc = 0;
    while (!resp_valid && cyc < 30) begin @(posedge clk); #1; cyc++; end
    chk("bp_after_data", 32'(resp_data), 32'd6);
    chk("bp_after_id", 32'(resp_id), 32'd0);
    wait_idle();

    // asynchronous reset while an operation is executing
    req_a[1*N +: N] = 8'd1; req_b[1*N +: N] = 8'd2; req_sub[1] = 1'b0;
    req_valid = 4'b0010;
    #1;
    cyc = 0;
    while (!req_ready[1] && cyc < 30) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    req_a[3*N +: N] = 8'h80; req_b[3*N +: N] = 8'h7F; req_sub[3] = 1'b1;
    req_valid = 4'b1000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("arst_req3_grant", 32'(req_ready), 32'b1000);
    do_op(3, 8'h80, 8'h7F, 1'b1, g, d, rid, lat);
    chk("arst_data", 32'(d), 32'h101);
    chk("arst_id", 32'(rid), 32'd3);
    wait_idle();

    // random operands, requesters and back-pressure; model checks every cycle
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 8'($urandom); req_b[i*N +: N] = 8'($urandom);
      req_sub[i] = 1'($urandom); waits[i] = 0; grants[i] = 0;
    end
    req_valid = 4'($urandom_range(1, 15));
    acc = 0; cyc = 0; maxw = 0; pend_g = -1;
    while (acc < 50 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      resp_ready = ($urandom % 4) != 0;
      if (pend_g >= 0) begin
        req_a[pend_g*N +: N] = 8'($urandom); req_b[pend_g*N +: N] = 8'($urandom);
        req_sub[pend_g] = 1'($urandom);
        req_valid[pend_g] = ($urandom % 4) != 0;
        for (int i = 0; i < NREQ; i++) begin
          if (!req_valid[i] && i != pend_g && ($urandom % 2) == 1) begin
            req_a[i*N +: N] = 8'($urandom); req_b[i*N +: N] = 8'($urandom);
            req_sub[i] = 1'($urandom); req_valid[i] = 1'b1;
          end
        end
        pend_g = -1;
      end
      #1;
      if ((req_ready & req_valid) != '0) begin
        pend_g = m_idx(req_ready & req_valid);
        grants[pend_g]++;
        acc++;
        for (int i = 0; i < NREQ; i++) begin
          if (i != pend_g && req_valid[i]) begin
            waits[i]++;
            if (waits[i] > maxw) maxw = waits[i];
          end
        end
        waits[pend_g] = 0;
        $display("[TB] rand grant req=%0d a=%0d b=%0d sub=%0d", pend_g,
                 $signed(req_a[pend_g*N +: N]), $signed(req_b[pend_g*N +: N]), req_sub[pend_g]);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    resp_ready = 1'b1;
    wait_idle();
    chk("rand_progress", 32'(acc), 32'd50);
    chk("rand_max_wait_ok", 32'(maxw <= NREQ - 1), 32'd1);
    for (int i = 0; i < NREQ; i++) chk("rand_not_starved", 32'(grants[i] > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
